// File: rtl/popcount_seq.sv
// popcount_seq: counts set bits of a WIDTH-bit word by feeding one shared
// 8-bit popcount unit a byte per cycle, least significant byte first.
// Ports: CLK, RESET (sync, active-high), I_VALID/I_READY/I (word in),
//        O_VALID/O_READY/O (count out), BUSY (RUN or DONE).
// Optional: define POPCOUNT_SEQ_THRESH_EN to add THRESH in / GE out.

module popcount8 (
   input  logic [7:0] d_i,
   output logic [3:0] cnt_o
);
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < 8; i++) begin
         cnt_o = cnt_o + {3'b000, d_i[i]};
      end
   end
endmodule

module popcount_seq #(
   parameter  int WIDTH  = 32,
   localparam int NCHUNK = WIDTH / 8,
   localparam int OW     = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [WIDTH-1:0] I,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [OW-1:0]    O,
`ifdef POPCOUNT_SEQ_THRESH_EN
   input  logic [OW-1:0]    THRESH,
   output logic             GE,
`endif
   output logic             BUSY
);

   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [OW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OW-1:0]    o_q, o_d;
   logic [3:0]       pc8;
   logic [OW-1:0]    sum;
`ifdef POPCOUNT_SEQ_THRESH_EN
   logic [OW-1:0]    thr_q, thr_d;
   logic             ge_q, ge_d;
`endif

   // The single shared byte counter always looks at the low byte.
   popcount8 u_pc (
      .d_i   (sr_q[7:0]),
      .cnt_o (pc8)
   );

   assign sum = acc_q + OW'(pc8);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      o_d     = o_q;
`ifdef POPCOUNT_SEQ_THRESH_EN
      thr_d   = thr_q;
      ge_d    = ge_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (I_VALID) begin
               sr_d    = I;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef POPCOUNT_SEQ_THRESH_EN
               thr_d   = THRESH;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = sum;
            sr_d  = sr_q >> 8;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Final byte: publish the total in the same edge.
               o_d     = sum;
`ifdef POPCOUNT_SEQ_THRESH_EN
               ge_d    = (sum >= thr_q);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (O_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         o_q     <= '0;
`ifdef POPCOUNT_SEQ_THRESH_EN
         thr_q   <= '0;
         ge_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
`ifdef POPCOUNT_SEQ_THRESH_EN
         thr_q   <= thr_d;
         ge_q    <= ge_d;
`endif
      end
   end

   // Outputs are forced quiet while RESET is held.
   assign I_READY = (state_q == IDLE) && !RESET;
   assign O_VALID = (state_q == DONE) && !RESET;
   assign BUSY    = (state_q != IDLE) && !RESET;
   assign O       = RESET ? '0 : o_q;
`ifdef POPCOUNT_SEQ_THRESH_EN
   assign GE      = ge_q && !RESET;
`endif

endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Sequencing controller that time-shares one 8-bit population-count datapath across a wide input word.
- Accepts a WIDTH-bit word over a valid/ready handshake and feeds it to the shared 8-bit popcount unit one byte per cycle, least significant byte first.
- Accumulates the per-byte counts and presents the total over a second valid/ready handshake.
- Sits between a word producer and a result consumer; exactly one 8-bit popcount instance exists inside.

Parameters:
- WIDTH, 32, input word width in bits; must be a multiple of 8 and at least 8.
- NCHUNK, WIDTH/8, derived local value: number of bytes per word; not overridable.
- OW, clog2(WIDTH+1), derived local value: result width; 6 when WIDTH=32.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- I_VALID  input  1  producer has a word on I.
- I_READY  output  1  controller can accept a word; high only in IDLE and while RESET is low.
- I  input  WIDTH  word to count; sampled only on the accept edge.
- O_VALID  output  1  result on O is valid; high only in DONE.
- O_READY  input  1  consumer accepts the result.
- O  output  OW  total number of set bits in the accepted word.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- Reset:
  - RESET is sampled on the CLK edge; synchronous reset, active-high.
  - While RESET is high: next state is IDLE, O=0, O_VALID=0, BUSY=0, I_READY=0. Accumulator, shift register and chunk counter clear to 0.
  - RESET asserted mid-RUN or mid-DONE abandons the word; no O_VALID is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - I_READY=1.
  - On an edge with I_VALID=1: load the shift register with I, acc=0, cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - I_READY=0.
  - Each edge:
    - The low byte of the shift register drives the shared popcount unit.
    - acc <= acc + pc8 (zero-extended to OW bits; no overflow is possible).
    - The shift register shifts right by 8.
    - cnt <= cnt + 1.
  - On the edge where cnt == NCHUNK-1: O <= acc + pc8, then go to DONE.
- DONE:
  - O_VALID=1; O is held stable until the handshake.
  - On an edge with O_READY=1: go to IDLE, with O_VALID low from the next cycle.
  - No new word is accepted in the same edge; I_READY rises the cycle after the handshake.
  - O_READY low holds DONE indefinitely (backpressure).
- Latency and throughput:
  - O_VALID asserts exactly NCHUNK cycles after the input accept edge (4 for WIDTH=32, 1 for WIDTH=8).
  - With O_READY held high, the minimum word-to-word spacing is NCHUNK+2 cycles.
- Input value handling:
  - I is ignored except on the accept edge; changing I during RUN has no effect.
  - O keeps its last result after the output handshake until the next entry to DONE.
- O_VALID and I_READY are never high together.

Optional Feature:
- Macro POPCOUNT_SEQ_THRESH_EN.
- When defined:
  - Adds input THRESH [OW] and output GE [1].
  - GE is registered together with O on entry to DONE: GE = (final count >= THRESH), with THRESH sampled on the input accept edge.
  - GE is 0 in reset and is held with O.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- WIDTH=32, I=0xFFFFFFFF accepted at edge t, O_READY=1 -> O_VALID high 4 cycles after t, O=32, then IDLE with I_READY=1 one cycle after the output handshake.
- I=0x00000000 -> O=0; I=0x80000001 -> O=2; I=0x0F0F00F1 -> O=13; each with latency 4.
- Result 0xA5A5A5A5 (O=16) with O_READY low for 5 cycles -> O_VALID and O=16 held stable, I_READY=0 throughout; O_READY high -> IDLE next cycle.
- Two back-to-back words 0x000000FF then 0xFF000000 with I_VALID and O_READY always high -> O=8 then O=8, accept edges 6 cycles apart.
- RESET pulsed for 1 cycle 2 cycles after accepting 0xFFFFFFFF -> no O_VALID, O=0, I_READY=1 after reset; next word 0x3 -> O=2.
- With POPCOUNT_SEQ_THRESH_EN and WIDTH=8: THRESH=4, I=0x0F -> O=4, GE=1, latency 1; I=0x07 -> O=3, GE=0.
